// File: rtl/alu_pipe.sv
// alu_pipe: two-stage WIDTH-bit ALU with valid/ready handshakes on both sides.
// S1 registers the conditioned operands; S2 computes the result and flags.
// Optional output counters are included when ALU_PIPE_STATS_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  input  logic [2:0]       bonus_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
`ifdef ALU_PIPE_STATS_EN
  ,
  output logic [15:0]      op_cnt_o,
  output logic [15:0]      ovf_cnt_o
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [1:0]       s1_op;
  logic [2:0]       s1_bonus;
  logic             s1_eq;

  logic             s2_adv;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             carry_msb;
  logic             sum_ovf;
  logic             lt;
  logic             cmp;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_cout;
  logic             nxt_ovf;

  assign s2_adv     = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~s1_valid | s2_adv;

  // S1 occupancy: refills whenever the stage can accept, otherwise holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
    end
  end

  // S1 data: operand conditioning; loads only on an accepted transfer
  always_ff @(posedge clk_i) begin
    if (in_valid_i && in_ready_o) begin
      s1_a     <= ctrl_i[3] ? ~src1_i : src1_i;
      s1_b     <= ctrl_i[2] ? ~src2_i : src2_i;
      s1_cin   <= ctrl_i[2];
      s1_op    <= ctrl_i[1:0];
      s1_bonus <= bonus_i;
      s1_eq    <= (src1_i == src2_i);
    end
  end

  // Adder and signed overflow; carry into the MSB is recovered from the sum bit
  assign sum_ext   = {1'b0, s1_a} + {1'b0, s1_b} + {{WIDTH{1'b0}}, s1_cin};
  assign sum       = sum_ext[WIDTH-1:0];
  assign carry     = sum_ext[WIDTH];
  assign carry_msb = s1_a[WIDTH-1] ^ s1_b[WIDTH-1] ^ sum[WIDTH-1];
  assign sum_ovf   = carry_msb ^ carry;
  assign lt        = sum[WIDTH-1] ^ sum_ovf;

  // S2 result select for logic, arithmetic and compare operations
  always_comb begin
    nxt_result = '0;
    nxt_cout   = 1'b0;
    nxt_ovf    = 1'b0;
    cmp        = 1'b0;
    case (s1_bonus)
      3'b000:  cmp = lt;
      3'b001:  cmp = ~lt & ~s1_eq;
      3'b010:  cmp = lt | s1_eq;
      3'b011:  cmp = ~lt;
      3'b100:  cmp = s1_eq;
      3'b101:  cmp = ~s1_eq;
      default: cmp = 1'b0;
    endcase
    case (s1_op)
      2'b00: nxt_result = s1_a & s1_b;
      2'b01: nxt_result = s1_a | s1_b;
      2'b10: begin
        nxt_result = sum;
        nxt_cout   = carry;
        nxt_ovf    = sum_ovf;
      end
      default: begin
        nxt_result = {{(WIDTH-1){1'b0}}, cmp};
        nxt_cout   = carry;
        nxt_ovf    = sum_ovf;
      end
    endcase
  end

  // S2 output register: advances when empty or drained, holds under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      cout_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else if (s2_adv) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        result_o   <= nxt_result;
        zero_o     <= (nxt_result == '0);
        cout_o     <= nxt_cout;
        overflow_o <= nxt_ovf;
      end
    end
  end

`ifdef ALU_PIPE_STATS_EN
  logic [1:0] s2_op;

  // Operation tag carried alongside the result so the counter can qualify adds
  always_ff @(posedge clk_i) begin
    if (s2_adv && s1_valid) begin
      s2_op <= s1_op;
    end
  end

  // Transfer counters, free-running with natural 16-bit wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_cnt_o  <= '0;
      ovf_cnt_o <= '0;
    end else if (out_valid_o && out_ready_i) begin
      op_cnt_o <= op_cnt_o + 16'd1;
      if (overflow_o && (s2_op == 2'b10)) begin
        ovf_cnt_o <= ovf_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with a scoreboard queue; the monitor pops
// and compares on every output transfer.
module tb_alu_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic [3:0]  ctrl_i = '0;
  logic [2:0]  bonus_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        cout_o;
  logic        overflow_o;
`ifdef ALU_PIPE_STATS_EN
  logic [15:0] op_cnt_o;
  logic [15:0] ovf_cnt_o;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // expected = {result, zero, cout, overflow}
  logic [34:0] exp_q[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .bonus_i(bonus_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
`ifdef ALU_PIPE_STATS_EN
    , .op_cnt_o(op_cnt_o), .ovf_cnt_o(ovf_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: an output transfer happens on the next rising edge
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got 0x%0h, expected none", result_o);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("result", {32'd0, result_o}, {32'd0, e[34:3]});
        check("zero",   {63'd0, zero_o},     {63'd0, e[2]});
        check("cout",   {63'd0, cout_o},     {63'd0, e[1]});
        check("ovf",    {63'd0, overflow_o}, {63'd0, e[0]});
      end
    end
  end

  // called at #1 after a rising edge; returns at #1 after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                       input logic [2:0] bo, input logic [31:0] r, input logic z,
                       input logic co, input logic ov);
    bit done = 0;
    src1_i = a; src2_i = b; ctrl_i = c; bonus_i = bo; in_valid_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        exp_q.push_back({r, z, co, ov});
        done = 1;
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL issue_timeout: got in_ready=0, expected 1");
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    // reset state (still in reset)
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready_o},  64'd1);
    check("rst_result",    {32'd0, result_o},    64'd0);
    rst_i = 1'b0;

    // arithmetic
    issue(32'h7FFFFFFF, 32'h1, 4'b0010, 3'b000, 32'h80000000, 0, 0, 1);
    issue(32'd5, 32'd5, 4'b0110, 3'b000, 32'h0, 1, 1, 0);
    // compares
    issue(32'h80000000, 32'h1, 4'b0111, 3'b000, 32'h1, 0, 1, 1);
    issue(32'h80000000, 32'h1, 4'b0111, 3'b011, 32'h0, 1, 1, 1);
    issue(32'h1234, 32'h1234, 4'b0111, 3'b100, 32'h1, 0, 1, 0);
    issue(32'h1234, 32'h1234, 4'b0111, 3'b101, 32'h0, 1, 1, 0);
    issue(32'h1234, 32'h1234, 4'b0111, 3'b010, 32'h1, 0, 1, 0);
    issue(32'h1234, 32'h1234, 4'b0111, 3'b001, 32'h0, 1, 1, 0);
    issue(32'h1234, 32'h1234, 4'b0111, 3'b110, 32'h0, 1, 1, 0);
    // logic
    issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 3'b000, 32'h000F000F, 0, 0, 0);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b1101, 3'b000, 32'h0FFF0FFF, 0, 0, 0);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 3'b000, 32'hF000F000, 0, 0, 0);
    issue(32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 3'b000, 32'hFFF0FFF0, 0, 0, 0);
    repeat (4) @(posedge clk_i);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // backpressure: two accepted, third refused until the first drains
    out_ready_i = 1'b0;
    issue(32'd1, 32'd2, 4'b0010, 3'b000, 32'd3, 0, 0, 0);
    issue(32'd10, 32'd20, 4'b0010, 3'b000, 32'd30, 0, 0, 0);
    src1_i = 32'd100; src2_i = 32'd200; ctrl_i = 4'b0010; bonus_i = 3'b000;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_in_ready", {63'd0, in_ready_o}, 64'd0);
      check("bp_hold_result", {32'd0, result_o}, 64'd3);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_accept_on_drain", {63'd0, in_ready_o}, 64'd1);
    if (in_ready_o) exp_q.push_back({32'd300, 1'b0, 1'b0, 1'b0});
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check("bp_drain_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-flight with both stages full
    out_ready_i = 1'b0;
    issue(32'd7, 32'd8, 4'b0010, 3'b000, 32'd15, 0, 0, 0);
    issue(32'd9, 32'd9, 4'b0010, 3'b000, 32'd18, 0, 0, 0);
    check("full_in_ready", {63'd0, in_ready_o}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("mid_rst_in_ready",  {63'd0, in_ready_o},  64'd1);
    check("mid_rst_result",    {32'd0, result_o},    64'd0);
    check("mid_rst_flags",     {61'd0, zero_o, cout_o, overflow_o}, 64'd0);
`ifdef ALU_PIPE_STATS_EN
    check("mid_rst_op_cnt",  {48'd0, op_cnt_o},  64'd0);
    check("mid_rst_ovf_cnt", {48'd0, ovf_cnt_o}, 64'd0);
`endif
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("post_rst_no_output", {63'd0, out_valid_o}, 64'd0);

`ifdef ALU_PIPE_STATS_EN
    issue(32'h7FFFFFFF, 32'h1, 4'b0010, 3'b000, 32'h80000000, 0, 0, 1);
    repeat (3) @(posedge clk_i);
    #1;
    check("op_cnt",  {48'd0, op_cnt_o},  64'd1);
    check("ovf_cnt", {48'd0, ovf_cnt_o}, 64'd1);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_i);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised WIDTH-bit ALU with two pipeline stages and valid/ready handshakes on input and output.
- Keeps the existing control encoding: A_invert, B_invert and a 2-bit operation select.
- Adds a 3-bit bonus compare select (SLT/SGT/SLE/SGE/SEQ/SNE), overflow-corrected signed compare, and zero/cout/overflow flags.
- Sits between the decode/register-read stage and writeback in the lab CPU datapath.

Parameters:
WIDTH  32  operand/result width in bits; legal range 2..64

Ports:
clk_i        in   1      clock, rising edge
rst_i        in   1      reset, synchronous, active-high
in_valid_i   in   1      operand/op presented
in_ready_o   out  1      block can accept this cycle
src1_i       in   WIDTH  operand A
src2_i       in   WIDTH  operand B
ctrl_i       in   4      {A_invert, B_invert, operation[1:0]}
bonus_i      in   3      compare select; used only when operation==2'b11
out_valid_o  out  1      result valid
out_ready_i  in   1      consumer accepts result
result_o     out  WIDTH  result
zero_o       out  1      result_o == 0
cout_o       out  1      adder carry out of MSB
overflow_o   out  1      signed overflow

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high (clk_i, rst_i).
- Reset values (next edge with rst_i=1):
  - s1_valid=0, s2_valid=0, out_valid_o=0.
  - result_o=0, zero_o=0, cout_o=0, overflow_o=0.
  - in_ready_o is 1 after reset.
  - Reset mid-operation discards all in-flight transactions; nothing is emitted afterwards.
- Transfers: input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
- Stage 1 (S1) registers real_a, real_b, carry-in, operation, bonus_i and an equal flag:
  - real_a = A_invert ? ~src1_i : src1_i; real_b likewise with B_invert.
  - carry-in = B_invert.
  - equal = (src1_i == src2_i), taken on raw operands.
- Stage 2 (S2) computes from S1 and registers the outputs:
  - sum = real_a + real_b + cin, WIDTH bits plus carry.
  - operation 00: result = real_a & real_b; cout=0, overflow=0. Covers AND and NOR.
  - operation 01: result = real_a | real_b; cout=0, overflow=0. Covers OR and NAND.
  - operation 10: result = sum; cout = carry out.
  - overflow (arithmetic and compare ops) = carry into MSB XOR carry out of MSB.
  - operation 11: cout/overflow as for sum; result = {WIDTH-1 zeros, cmp}, with lt = sum[MSB] ^ overflow:
    - 000 SLT: lt
    - 001 SGT: ~lt & ~equal
    - 010 SLE: lt | equal
    - 011 SGE: ~lt
    - 100 SEQ: equal
    - 101 SNE: ~equal
    - 110, 111: 0
  - Compare is only meaningful with ctrl_i=0111; other invert settings are computed literally with no error.
  - zero_o = (result == 0), registered with result.
- Pipeline advance:
  - s2_adv = ~s2_valid | out_ready_i.
  - s1_adv = s2_adv.
  - in_ready_o = ~s1_valid | s2_adv (combinational, no dependency on in_valid_i).
- Latency: accepted on edge N gives out_valid_o=1 after edge N+1 when unstalled. Throughput is 1 per cycle.
- Backpressure:
  - While out_valid_o=1 and out_ready_i=0, result_o and all flags hold stable.
  - At most 2 transactions are in flight; the third is refused (in_ready_o=0) until a drain.
- Simultaneous accept and drain in the same cycle with both stages full: both advance, no bubble, order preserved.
- Bubbles: empty S1 with s2_adv moves a bubble into S2 (out_valid_o=0 next cycle).
- Data registers: S1/S2 data registers load only on a valid advance; they may retain stale data while invalid.

Optional Feature:
Macro ALU_PIPE_STATS_EN.
- Defined:
  - Adds output ports op_cnt_o[15:0] and ovf_cnt_o[15:0].
  - op_cnt_o increments on every output transfer.
  - ovf_cnt_o increments on an output transfer whose overflow_o=1 and whose operation is 10.
  - Both counters wrap 0xFFFF->0 and reset to 0 on rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD, WIDTH=32: src1=0x7FFFFFFF, src2=1, ctrl=0010, out_ready=1 -> two cycles later result=0x80000000, overflow=1, cout=0, zero=0.
- SUB: src1=5, src2=5, ctrl=0110 -> result=0, zero=1, cout=1, overflow=0.
- Compare, ctrl=0111:
  - src1=0x80000000, src2=1, bonus=000 -> result=1 (overflow-corrected).
  - src1=src2=0x1234: bonus=100 -> 1, bonus=101 -> 0, bonus=010 -> 1, bonus=001 -> 0.
- Logic: src1=0xF0F0F0F0, src2=0xFF00FF00:
  - NOR (1100) -> 0x000F000F.
  - NAND (1101) -> 0x0FFF0FFF.
  - cout=0, overflow=0.
- Backpressure: out_ready=0, issue 3 back-to-back valid ops -> 2 accepted, in_ready_o=0 on the third; result_o stable. Raise out_ready -> results emerge in issue order, one per cycle; third accepted the same cycle the first drains.
- Reset mid-flight: both stages full, rst_i=1 for one cycle -> next cycle out_valid_o=0, in_ready_o=1, outputs 0. With ALU_PIPE_STATS_EN: op_cnt_o=0, ovf_cnt_o=0, and 0x7FFFFFFF+1 drained -> op_cnt_o=1, ovf_cnt_o=1.
